// File: rtl/unidad_control_multiciclo_if.sv
// unidad_control_multiciclo_if: control bus between the multicycle MIPS control FSM and its datapath
interface unidad_control_multiciclo_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] dataUC;
  logic [1:0] PCSrc;
  logic       ilegal;
  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, dataUC, PCSrc, ilegal
  );
  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, dataUC, PCSrc, ilegal
  );
endinterface

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: Moore control FSM sequencing a multicycle MIPS datapath
module unidad_control_multiciclo #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  unidad_control_multiciclo_if.master bus,
  output logic [3:0]              estado_o,
  output logic [CNT_W-1:0]        instr_cnt_o
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    EXEC_I = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inc;
  assign estado_o    = state_q;
  assign instr_cnt_o = cnt_q;
  // state, lw/sw-addi/slti selector latched at DECODE, and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state and Moore outputs; sel_q=1 means sw (memory path) or slti (immediate path)
  always_comb begin
    state_d          = FETCH;
    sel_d            = sel_q;
    inc              = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.RegDst       = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.dataUC       = 3'b000;
    bus.PCSrc        = 2'b00;
    bus.ilegal       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        state_d     = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        sel_d       = (bus.Opcode == OP_SW) || (bus.Opcode == OP_SLTI);
        case (bus.Opcode)
          OP_R:             state_d = EXEC_R;
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_BEQ:           state_d = BRANCH;
          OP_ADDI, OP_SLTI: state_d = EXEC_I;
          OP_J:             state_d = JUMP;
          default:          bus.ilegal = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = sel_q ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        inc          = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        inc          = bus.mem_ready;
        state_d      = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.dataUC  = 3'b010;
        state_d     = RWB;
      end
      RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        inc          = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.dataUC      = 3'b001;
        bus.PCWriteCond = 1'b1;
        bus.PCSrc       = 2'b01;
        inc             = 1'b1;
      end
      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.dataUC  = sel_q ? 3'b111 : 3'b000;
        state_d     = IWB;
      end
      IWB: begin
        bus.RegWrite = 1'b1;
        inc          = 1'b1;
      end
      JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'b10;
        inc         = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    cnt_d = cnt_q + CNT_W'(inc);
  end
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: directed-vector bench for the multicycle control FSM
`timescale 1ns/100ps
module tb_unidad_control_multiciclo;
  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;
  // field order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB dataUC PCSrc ilegal
  localparam logic [17:0] C_FW  = 18'b0_0_0_1_0_0_0_0_0_0_01_000_00_0;
  localparam logic [17:0] C_FGO = 18'b1_0_0_1_0_1_0_0_0_0_01_000_00_0;
  localparam logic [17:0] C_DEC = 18'b0_0_0_0_0_0_0_0_0_0_11_000_00_0;
  localparam logic [17:0] C_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_000_00_1;
  localparam logic [17:0] C_MAD = 18'b0_0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [17:0] C_MRD = 18'b0_0_1_1_0_0_0_0_0_0_00_000_00_0;
  localparam logic [17:0] C_MWB = 18'b0_0_0_0_0_0_0_1_1_0_00_000_00_0;
  localparam logic [17:0] C_MWR = 18'b0_0_1_0_1_0_0_0_0_0_00_000_00_0;
  localparam logic [17:0] C_EXR = 18'b0_0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [17:0] C_RWB = 18'b0_0_0_0_0_0_1_0_1_0_00_000_00_0;
  localparam logic [17:0] C_BR  = 18'b0_1_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [17:0] C_EXA = 18'b0_0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [17:0] C_EXS = 18'b0_0_0_0_0_0_0_0_0_1_10_111_00_0;
  localparam logic [17:0] C_IWB = 18'b0_0_0_0_0_0_0_0_1_0_00_000_00_0;
  localparam logic [17:0] C_JMP = 18'b1_0_0_0_0_0_0_0_0_0_00_000_10_0;
  typedef struct packed {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  estado, estado4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;
  logic [17:0] ctl;
  int          vecs = 0;
  int          errs = 0;
  unidad_control_multiciclo_if bus ();
  unidad_control_multiciclo_if bus4 ();
  assign bus4.Opcode    = bus.Opcode;
  assign bus4.mem_ready = bus.mem_ready;
  assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.dataUC,
                bus.PCSrc, bus.ilegal};
  unidad_control_multiciclo #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master), .estado_o(estado), .instr_cnt_o(cnt)
  );
  unidad_control_multiciclo #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.master), .estado_o(estado4), .instr_cnt_o(cnt4)
  );
  always #5 clk = ~clk;
  // drive one cycle's inputs at the falling edge and settle before the next rising edge
  task automatic apply(input logic [5:0] op, input logic mr);
    @(negedge clk);
    bus.Opcode    = op;
    bus.mem_ready = mr;
    #4;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.Opcode = R;
    bus.mem_ready = 1'b0;
    #2;
    vecs++;
    if ({estado, ctl} !== {4'd0, C_FW}) begin
      errs++;
      $display("FAIL reset_outputs: estado=%0d ctl=%b, expected estado=0 ctl=%b", estado, ctl, C_FW);
    end
    vecs++;
    if (cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_cnt: got %0d expected 0", cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_rtype();
    vec_t t [5];
    t = '{{R,1'b1,4'd0,C_FGO}, {R,1'b0,4'd1,C_DEC}, {R,1'b0,4'd6,C_EXR}, {R,1'b0,4'd7,C_RWB},
          {R,1'b0,4'd0,C_FW}};
    for (int i = 0; i < 5; i++) begin
      apply(t[i].op, t[i].mr);
      vecs++;
      if ({estado, ctl} !== {t[i].st, t[i].ctl}) begin
        errs++;
        $display("FAIL rtype[%0d]: estado=%0d ctl=%b, expected estado=%0d ctl=%b", i, estado, ctl, t[i].st, t[i].ctl);
      end
    end
    vecs++;
    if (cnt !== 16'd1) begin
      errs++;
      $display("FAIL rtype_cnt: got %0d expected 1", cnt);
    end
  endtask
  task automatic test_async_reset();
    vec_t t [7];
    t = '{{R,1'b1,4'd0,C_FGO}, {R,1'b0,4'd1,C_DEC}, {R,1'b0,4'd6,C_EXR},
          {SW,1'b1,4'd0,C_FGO}, {SW,1'b0,4'd1,C_DEC}, {SW,1'b0,4'd2,C_MAD}, {SW,1'b0,4'd5,C_MWR}};
    for (int i = 0; i < 7; i++) begin
      apply(t[i].op, t[i].mr);
      vecs++;
      if ({estado, ctl} !== {t[i].st, t[i].ctl}) begin
        errs++;
        $display("FAIL async_reset[%0d]: estado=%0d ctl=%b, expected estado=%0d ctl=%b", i, estado, ctl, t[i].st, t[i].ctl);
      end
      if (i == 2 || i == 6) begin
        #0.5 rst_n = 1'b0;
        #0.2;
        vecs++;
        if ({estado, ctl, cnt} !== {4'd0, C_FW, 16'd0}) begin
          errs++;
          $display("FAIL async_reset_hit[%0d]: estado=%0d ctl=%b cnt=%0d, expected estado=0 ctl=%b cnt=0", i, estado, ctl, cnt, C_FW);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask
  task automatic test_lw_waits();
    vec_t t [9];
    t = '{{LW,1'b0,4'd0,C_FW}, {LW,1'b0,4'd0,C_FW}, {LW,1'b1,4'd0,C_FGO}, {LW,1'b0,4'd1,C_DEC},
          {SW,1'b0,4'd2,C_MAD}, {SW,1'b0,4'd3,C_MRD}, {SW,1'b1,4'd3,C_MRD}, {SW,1'b0,4'd4,C_MWB},
          {SW,1'b0,4'd0,C_FW}};
    for (int i = 0; i < 9; i++) begin
      apply(t[i].op, t[i].mr);
      vecs++;
      if ({estado, ctl} !== {t[i].st, t[i].ctl}) begin
        errs++;
        $display("FAIL lw[%0d]: estado=%0d ctl=%b, expected estado=%0d ctl=%b", i, estado, ctl, t[i].st, t[i].ctl);
      end
    end
    vecs++;
    if (cnt !== 16'd1) begin
      errs++;
      $display("FAIL lw_cnt: got %0d expected 1", cnt);
    end
  endtask
  task automatic test_sw_wait();
    vec_t t [6];
    t = '{{SW,1'b1,4'd0,C_FGO}, {SW,1'b0,4'd1,C_DEC}, {LW,1'b0,4'd2,C_MAD}, {LW,1'b0,4'd5,C_MWR},
          {LW,1'b1,4'd5,C_MWR}, {LW,1'b0,4'd0,C_FW}};
    for (int i = 0; i < 6; i++) begin
      apply(t[i].op, t[i].mr);
      vecs++;
      if ({estado, ctl} !== {t[i].st, t[i].ctl}) begin
        errs++;
        $display("FAIL sw[%0d]: estado=%0d ctl=%b, expected estado=%0d ctl=%b", i, estado, ctl, t[i].st, t[i].ctl);
      end
    end
    vecs++;
    if (cnt !== 16'd2) begin
      errs++;
      $display("FAIL sw_cnt: got %0d expected 2", cnt);
    end
  endtask
  task automatic test_beq_imm_jump();
    vec_t t [15];
    t = '{{BEQ,1'b1,4'd0,C_FGO}, {BEQ,1'b0,4'd1,C_DEC}, {BEQ,1'b0,4'd8,C_BR},
          {SLTI,1'b1,4'd0,C_FGO}, {SLTI,1'b0,4'd1,C_DEC}, {ADDI,1'b0,4'd9,C_EXS}, {ADDI,1'b0,4'd10,C_IWB},
          {ADDI,1'b1,4'd0,C_FGO}, {ADDI,1'b0,4'd1,C_DEC}, {SLTI,1'b0,4'd9,C_EXA}, {SLTI,1'b0,4'd10,C_IWB},
          {J,1'b1,4'd0,C_FGO}, {J,1'b0,4'd1,C_DEC}, {J,1'b0,4'd11,C_JMP}, {J,1'b0,4'd0,C_FW}};
    for (int i = 0; i < 15; i++) begin
      apply(t[i].op, t[i].mr);
      vecs++;
      if ({estado, ctl} !== {t[i].st, t[i].ctl}) begin
        errs++;
        $display("FAIL beq_imm_j[%0d]: estado=%0d ctl=%b, expected estado=%0d ctl=%b", i, estado, ctl, t[i].st, t[i].ctl);
      end
    end
    vecs++;
    if (cnt !== 16'd6) begin
      errs++;
      $display("FAIL beq_imm_j_cnt: got %0d expected 6", cnt);
    end
  endtask
  task automatic test_illegal();
    vec_t t [4];
    t = '{{BAD,1'b1,4'd0,C_FGO}, {BAD,1'b0,4'd1,C_ILL}, {BAD,1'b0,4'd0,C_FW}, {R,1'b0,4'd0,C_FW}};
    for (int i = 0; i < 4; i++) begin
      apply(t[i].op, t[i].mr);
      vecs++;
      if ({estado, ctl} !== {t[i].st, t[i].ctl}) begin
        errs++;
        $display("FAIL illegal[%0d]: estado=%0d ctl=%b, expected estado=%0d ctl=%b", i, estado, ctl, t[i].st, t[i].ctl);
      end
    end
    vecs++;
    if (cnt !== 16'd6) begin
      errs++;
      $display("FAIL illegal_cnt: got %0d expected 6", cnt);
    end
  endtask
  task automatic test_back_to_back_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply(J, 1'b1);
      if (i == 15) begin
        vecs++;
        if ({estado4, cnt4} !== {4'd0, 4'd15}) begin
          errs++;
          $display("FAIL wrap_pre: estado=%0d cnt4=%0d, expected estado=0 cnt4=15", estado4, cnt4);
        end
      end
      apply(J, 1'b0);
      apply(J, 1'b0);
    end
    apply(J, 1'b0);
    vecs++;
    if ({estado4, cnt4} !== {4'd0, 4'd0}) begin
      errs++;
      $display("FAIL wrap_cnt4: estado=%0d cnt4=%0d, expected estado=0 cnt4=0", estado4, cnt4);
    end
    vecs++;
    if (cnt !== 16'd16) begin
      errs++;
      $display("FAIL wrap_cnt16: got %0d expected 16", cnt);
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_async_reset();
    test_lw_waits();
    test_sw_wait();
    test_beq_imm_jump();
    test_illegal();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

- Moore-style control FSM that sequences the team's multicycle MIPS datapath: memory, instruction register, register file, PC, and the ALU through its ALU-control decoder.
- Decodes the 6-bit opcode and steps each instruction through fetch/decode/execute/memory/writeback.
- Drives the 3-bit `dataUC` code consumed by the ALU-control block (000 add, 001 sub, 010 use funct, 111 slt).
- Holds in memory states until the memory handshake completes, and counts retired instructions.

## Interface
- `CNT_W`, default 16: width of retired-instruction counter.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Opcode` input 6: IR[31:26], valid from DECODE onward.
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite` output 1: unconditional PC load.
- `PCWriteCond` output 1: PC load if datapath Zero=1 (datapath ANDs).
- `IorD` output 1: 0=PC addresses memory, 1=ALUOut.
- `MemRead` output 1; `MemWrite` output 1.
- `IRWrite` output 1: load instruction register.
- `RegDst` output 1: 0=rt, 1=rd.
- `MemtoReg` output 1: 0=ALUOut, 1=MDR.
- `RegWrite` output 1.
- `ALUSrcA` output 1: 0=PC, 1=regA.
- `ALUSrcB` output 2: 00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `dataUC` output 3: ALU-control code.
- `PCSrc` output 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `ilegal` output 1: one-cycle pulse on unsupported opcode.
- `estado` output 4: current state code (debug).
- `instr_cnt` output CNT_W: retired-instruction count.

## Operation
- States and codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, BRANCH=8, EXEC_I=9, IWB=10, JUMP=11.
  - Codes 12–15 are unreachable; if entered, next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, dataUC=000, PCSrc=00.
  - IRWrite and PCWrite assert only in a cycle with mem_ready=1; the state then advances to DECODE. Otherwise it holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, dataUC=000 (branch target precompute). Next state by Opcode:
  - 000000 (R) → EXEC_R
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) and 001010 (slti) → EXEC_I
  - 000010 (j) → JUMP
  - any other opcode → FETCH, with `ilegal`=1 for that DECODE cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, dataUC=000. lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then → FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, dataUC=010 → RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, dataUC=001, PCWriteCond=1, PCSrc=01 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, dataUC=000 for addi or 111 for slti → IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
- JUMP: PCWrite=1, PCSrc=10 → FETCH.
- Decode-memory: a 1-bit register records lw vs sw, and addi vs slti, at DECODE. Later states use this register, not live Opcode.
- Default values, for any output not listed in a state: all 1-bit outputs 0, ALUSrcB=00, dataUC=000, PCSrc=00.
- `instr_cnt` increments by 1, wrapping modulo 2^CNT_W, on entry to FETCH from:
  - MEMWB, MEMWR (with mem_ready), RWB, BRANCH, IWB, JUMP.
  - It does not increment on the illegal-opcode return.

## Timing
- State register and instr_cnt update on the rising clk edge. Outputs are combinational from state, plus mem_ready for IRWrite/PCWrite in FETCH.
- Reset (rst_n=0), effective immediately and regardless of clk:
  - state=FETCH, instr_cnt=0, ilegal=0.
  - Outputs equal FETCH values with mem_ready=0: MemRead=1, ALUSrcB=01, all others 0/000.
- Reset mid-instruction (including during a memory wait) abandons the instruction; no write strobe survives past reset assertion.
- Cycle counts with zero wait states: R/addi/slti 4, lw 5, sw 4, beq 3, j 3, illegal 2.
  - Each memory wait cycle adds 1.
- MemRead and MemWrite are never asserted together. RegWrite is never asserted in a memory-wait cycle.

## Test plan
- Reset: drive rst_n=0 mid-EXEC_R, asynchronous to clk → estado=0, instr_cnt=0, MemRead=1, RegWrite=0 in the same cycle.
- R-type: Opcode=000000, mem_ready=1 → estado 0,1,6,7,0; dataUC=010 in EXEC_R; RegWrite=1 with RegDst=1 in RWB; instr_cnt +1.
- lw with 2 wait cycles in FETCH and 1 in MEMRD:
  - → IRWrite only on the mem_ready cycle.
  - → total 8 cycles; MemtoReg=1 and RegWrite=1 in MEMWB.
- beq/slti/j:
  - beq → PCWriteCond=1, dataUC=001 in BRANCH.
  - slti → dataUC=111 in EXEC_I.
  - j → PCWrite=1, PCSrc=10.
- Illegal Opcode=111111 → ilegal pulse of 1 cycle in DECODE, back to FETCH, instr_cnt unchanged.
- Counter wrap: CNT_W=4, 16 jumps → instr_cnt returns to 0.
